adder_subtractor_8bit: RTL and testbench
========================================

ADDER_SUBTRACTOR_8BIT -- requirements
Module: adder_subtractor_8bit

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width; the block SHALL be verified at WIDTH=8 only.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  WIDTH  first operand (minuend when subtracting).
REQ-005 B  input  WIDTH  second operand (addend or subtrahend).
REQ-006 Op  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B).
REQ-007 in_valid  input  1  A, B and Op are sampled on a rising edge where in_valid=1.
REQ-008 Sum  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-009 Cout  output  1  registered carry out of the MSB (carry for add, not-borrow for subtract).
REQ-010 Overflow  output  1  registered two's-complement signed overflow flag.
REQ-011 Zero  output  1  registered flag, 1 when Sum==0.
REQ-012 Negative  output  1  registered copy of Sum[WIDTH-1].
REQ-013 out_valid  output  1  1 for exactly one cycle per accepted input.

Function
REQ-014 Subtraction SHALL be computed as A + ~B + 1, with B conditionally inverted by XOR with Op and Op driving the LSB carry-in.
REQ-015 Sum SHALL equal (A + (B^{WIDTH{Op}}) + Op) mod 2^WIDTH.
REQ-016 Cout SHALL equal bit WIDTH of that same (WIDTH+1)-bit sum; for subtract, Cout=1 means A>=B unsigned and Cout=0 means a borrow.
REQ-017 Overflow SHALL equal the XOR of the carry into the MSB and the carry out of the MSB.
REQ-018 Latency SHALL be exactly one clock: inputs sampled at edge N SHALL appear on all outputs after edge N, with out_valid=1.
REQ-019 When in_valid=0 at an edge, out_valid SHALL be 0 after that edge, and Sum, Cout, Overflow, Zero and Negative SHALL hold their previous values.
REQ-020 There is no backpressure; a new operation MAY be accepted every cycle, giving throughput of one result per clock.
REQ-021 Wrap-around SHALL be silent: 0xFF+0x01 SHALL give Sum=0x00 and Cout=1, with no saturation.
REQ-022 The datapath SHALL contain no latches; the adder SHALL be purely combinational between the input sampling point and the output registers.

Reset
REQ-023 When rst=1 at a rising edge, Sum, Cout, Overflow, Negative and out_valid SHALL be 0 and Zero SHALL be 1 after that edge.
REQ-024 rst SHALL take priority over in_valid; an operation presented in the same cycle as rst SHALL be discarded and SHALL produce no out_valid.
REQ-025 Reset asserted while a result is pending SHALL cancel that result.

Structure
REQ-026 A shared package adder_subtractor_pkg SHALL hold the constants OP_ADD=1'b0 and OP_SUB=1'b1 and the default width constant.
REQ-027 One sub-module, full_adder (inputs a, b, cin; outputs s, cout), SHALL be instantiated WIDTH times as a ripple-carry chain.
REQ-028 The carry vector SHALL be WIDTH+1 bits wide, with carry[0] = Op, carry[WIDTH] feeding Cout, and carry[WIDTH-1] feeding the Overflow computation.

Verification
REQ-029 Add 0x00+0x00 and 0x0F+0x01 -> Sum=0x00, Cout=0, Zero=1; then Sum=0x10, Cout=0, Overflow=0.
REQ-030 Subtract 0x0F-0x01 -> Sum=0x0E, Cout=1; subtract 0xF0-0x0F -> Sum=0xE1, Cout=1, Negative=1.
REQ-031 Add 0xF0+0x0F and 0xAA+0x55 -> Sum=0xFF, Cout=0, Negative=1 in both cases; subtract 0xAA-0x55 -> Sum=0x55, Cout=1, Overflow=1.
REQ-032 Add 0xFF+0x01 -> Sum=0x00, Cout=1, Zero=1, Overflow=0; subtract 0xFF-0x01 -> Sum=0xFE, Cout=1; add 0x7F+0x01 -> Sum=0x80, Overflow=1.
REQ-033 Back-to-back in_valid over 9 consecutive cycles -> 9 consecutive out_valid pulses, each carrying its own result one cycle later; a single in_valid=0 gap -> outputs hold and out_valid=0.
REQ-034 rst asserted in the same cycle as in_valid=1 -> no out_valid pulse and outputs at reset values; a randomized run of at least 10k operations SHALL match a reference model of A±B on all flags.

Source files
------------

// File: rtl/adder_subtractor_8bit_pkg.sv
// Shared constants for the registered ripple-carry adder/subtractor.
package adder_subtractor_pkg;
   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam logic        OP_ADD        = 1'b0;
   localparam logic        OP_SUB        = 1'b1;
endpackage

// File: rtl/adder_subtractor_8bit_if.sv
// Operand/result bus: the master drives operands and in_valid; the slave returns registered results.
interface adder_subtractor_8bit_if
   import adder_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Op;
   logic             in_valid;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Overflow;
   logic             Zero;
   logic             Negative;
   logic             out_valid;

   modport master (
      output A, B, Op, in_valid,
      input  Sum, Cout, Overflow, Zero, Negative, out_valid
   );

   modport slave (
      input  A, B, Op, in_valid,
      output Sum, Cout, Overflow, Zero, Negative, out_valid
   );
endinterface

// File: rtl/adder_subtractor_8bit_full_adder.sv
// One-bit full adder cell used as a ripple-carry stage.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_subtractor_8bit.sv
// Registered add/subtract unit: combinational ripple chain, one-cycle latency, flags held between operations.
module adder_subtractor_8bit
   import adder_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                    clk,
   input logic                    rst,
   adder_subtractor_8bit_if.slave bus
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum_c;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             neg_q;
   logic             valid_q;

   // Subtract as A + ~B + 1: Op inverts B and supplies the LSB carry-in.
   assign carry[0] = (bus.Op == OP_SUB);
   assign b_eff    = bus.B ^ {WIDTH{bus.Op}};

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder u_fa (
         .a    (bus.A[i]),
         .b    (b_eff[i]),
         .cin  (carry[i]),
         .s    (sum_c[i]),
         .cout (carry[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q  <= sum_c;
            cout_q <= carry[WIDTH];
            ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
            zero_q <= (sum_c == '0);
            neg_q  <= sum_c[WIDTH-1];
         end
      end
   end

   assign bus.Sum       = sum_q;
   assign bus.Cout      = cout_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Zero      = zero_q;
   assign bus.Negative  = neg_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_adder_subtractor_8bit.sv
// Bench for adder_subtractor_8bit: arithmetic reference model, per-cycle compare, literal directed vectors.
module tb_adder_subtractor_8bit;
   import adder_subtractor_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   adder_subtractor_8bit_if #(.WIDTH(8)) bus ();

   adder_subtractor_8bit #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // {Sum, Cout, Overflow, Zero, Negative} from plain integer arithmetic
   function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic op);
      int   ua, ub, sa, sb, r, sr;
      logic c, v;
      logic [7:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (op == OP_ADD) begin
         r  = ua + ub;
         sr = sa + sb;
         c  = (r > 255);
      end else begin
         r  = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end
      s = r[7:0];
      v = (sr > 127) || (sr < -128);
      return {s, c, v, (s == 8'h00), s[7]};
   endfunction

   localparam logic [12:0] RESET_VEC = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

   logic [12:0] exp_vec;
   logic        model_ready = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_vec <= RESET_VEC;
      end else if (bus.in_valid) begin
         exp_vec <= {1'b1, ref_op(bus.A, bus.B, bus.Op)};
      end else begin
         exp_vec <= {1'b0, exp_vec[11:0]};
      end
      model_ready <= 1'b1;
   end

   function automatic logic [12:0] dut_vec();
      return {bus.out_valid, bus.Sum, bus.Cout, bus.Overflow, bus.Zero, bus.Negative};
   endfunction

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (valid,sum,c,v,z,n)", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (model_ready) check("cycle", dut_vec(), exp_vec);
   end

   task automatic apply(input logic r, input logic iv, input logic [7:0] a, input logic [7:0] b, input logic op);
      rst          = r;
      bus.in_valid = iv;
      bus.A        = a;
      bus.B        = b;
      bus.Op       = op;
      @(posedge clk);
      #1;
   endtask

   // Directed op with its hand-computed result; pins both the model and the DUT.
   task automatic vec(input string name, input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic [12:0] req);
      apply(1'b0, 1'b1, a, b, op);
      check({name, "_model"}, {1'b1, ref_op(a, b, op)}, req);
      check(name, dut_vec(), req);
   endtask

   initial begin
      logic [12:0] held;
      apply(1'b1, 1'b0, 8'h00, 8'h00, OP_ADD);
      check("reset", dut_vec(), RESET_VEC);

      //                                   valid sum    c     v     z     n
      vec("add_00_00", 8'h00, 8'h00, OP_ADD, {1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
      vec("add_0f_01", 8'h0F, 8'h01, OP_ADD, {1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
      vec("sub_0f_01", 8'h0F, 8'h01, OP_SUB, {1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0});
      vec("sub_f0_0f", 8'hF0, 8'h0F, OP_SUB, {1'b1, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b1});
      vec("add_f0_0f", 8'hF0, 8'h0F, OP_ADD, {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
      vec("add_aa_55", 8'hAA, 8'h55, OP_ADD, {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
      vec("sub_aa_55", 8'hAA, 8'h55, OP_SUB, {1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0});
      vec("add_ff_01", 8'hFF, 8'h01, OP_ADD, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
      vec("sub_ff_01", 8'hFF, 8'h01, OP_SUB, {1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1});
      vec("add_7f_01", 8'h7F, 8'h01, OP_ADD, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1});
      vec("sub_80_01", 8'h80, 8'h01, OP_SUB, {1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0});
      vec("sub_00_01", 8'h00, 8'h01, OP_SUB, {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
      vec("sub_05_05", 8'h05, 8'h05, OP_SUB, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0});

      // Nine back-to-back operations, each result one cycle after its inputs
      for (int i = 0; i < 9; i++) begin
         apply(1'b0, 1'b1, 8'(i * 29 + 3), 8'(i * 17 + 100), i[0]);
         check("b2b_valid", {12'h000, bus.out_valid}, 13'h0001);
      end

      held = dut_vec();
      apply(1'b0, 1'b0, 8'h12, 8'h34, OP_ADD);
      check("gap_hold", dut_vec(), {1'b0, held[11:0]});

      apply(1'b0, 1'b1, 8'h7F, 8'h7F, OP_ADD);
      apply(1'b1, 1'b1, 8'h01, 8'h02, OP_ADD);
      check("rst_priority", dut_vec(), RESET_VEC);
      apply(1'b0, 1'b0, 8'h00, 8'h00, OP_ADD);
      check("rst_no_pulse", dut_vec(), RESET_VEC);

      for (int i = 0; i < 13000; i++) begin
         apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
               8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      apply(1'b0, 1'b0, 8'h00, 8'h00, OP_ADD);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
